// File: rtl/lcd_ctrl.sv
// HD44780 character-LCD responder: buffers LSU store words in a FIFO and replays each
// as a timed RS/DATA/EN bus cycle, exposing busy/full/overflow status for polling.
module lcd_ctrl #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned SETUP_CYC    = 3,
  parameter int unsigned EN_CYC       = 12,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned CMD_WAIT_CYC = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_vld,
  input  logic [31:0] i_req_data,
  input  logic        i_ovf_clr,
  output logic        o_req_rdy,
  output logic [31:0] o_status,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned FW     = AW + 1;
  localparam int unsigned Max0   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int unsigned Max1   = (Max0 > HOLD_CYC) ? Max0 : HOLD_CYC;
  localparam int unsigned Max2   = (Max1 > CMD_WAIT_CYC) ? Max1 : CMD_WAIT_CYC;
  localparam int unsigned MaxCyc = (Max2 > CLR_WAIT_CYC) ? Max2 : CLR_WAIT_CYC;
  localparam int unsigned CW     = $clog2(MaxCyc + 1);

  localparam logic [FW-1:0] FullCnt = FW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StWait} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [8:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]   fcnt_q;
  logic            clr_q, ovf_q, on_q, rs_q, en_q;
  logic [7:0]      data_q;

  logic            full, empty, accept, push, refuse, pop, head_clr, busy;
  logic [8:0]      head;
  logic            unused_bits;

  assign unused_bits = ^{i_req_data[29:10], i_req_data[8]};

  assign full      = (fcnt_q == FullCnt);
  assign empty     = (fcnt_q == '0);
  assign o_req_rdy = !full;
  assign accept    = i_req_vld && !full;
  assign push      = accept && !i_req_data[30];
  assign refuse    = i_req_vld && full;
  assign head      = mem_q[rd_ptr_q];
  // Clear-display and return-home commands need the long execution wait.
  assign head_clr  = !head[8] && (head[7:2] == 6'd0) && (head[1:0] != 2'd0);
  assign busy      = (state_q != StIdle) || !empty;

  assign o_status   = {29'd0, ovf_q, full, busy};
  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StSetup;
          cnt_d   = CW'(SETUP_CYC);
        end
      end
      StSetup: begin
        if (cnt_q == CW'(1)) begin
          state_d = StPulse;
          cnt_d   = CW'(EN_CYC);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StPulse: begin
        if (cnt_q == CW'(1)) begin
          state_d = StHold;
          cnt_d   = CW'(HOLD_CYC);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StHold: begin
        if (cnt_q == CW'(1)) begin
          state_d = StWait;
          cnt_d   = clr_q ? CW'(CLR_WAIT_CYC) : CW'(CMD_WAIT_CYC);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StWait: begin
        if (cnt_q == CW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      clr_q    <= 1'b0;
      on_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d == StPulse);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        rs_q     <= head[8];
        data_q   <= head[7:0];
        clr_q    <= head_clr;
      end
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + FW'(1);
        2'b01:   fcnt_q <= fcnt_q - FW'(1);
        default: fcnt_q <= fcnt_q;
      endcase
      if (accept) begin
        on_q <= i_req_data[31];
      end
      if (refuse) begin
        ovf_q <= 1'b1;
      end else if (i_ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset; the count and pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_req_data[9], i_req_data[7:0]};
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed self-checking bench for lcd_ctrl with shortened timing parameters.
module tb_lcd_ctrl;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_req_vld = 1'b0;
  logic [31:0] i_req_data = 32'h0;
  logic        i_ovf_clr = 1'b0;
  logic        o_req_rdy;
  logic [31:0] o_status;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .DEPTH       (4),
    .SETUP_CYC   (2),
    .EN_CYC      (3),
    .HOLD_CYC    (1),
    .CMD_WAIT_CYC(5),
    .CLR_WAIT_CYC(20)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_req_vld (i_req_vld),
    .i_req_data(i_req_data),
    .i_ovf_clr (i_ovf_clr),
    .o_req_rdy (o_req_rdy),
    .o_status  (o_status),
    .o_lcd_data(o_lcd_data),
    .o_lcd_rs  (o_lcd_rs),
    .o_lcd_rw  (o_lcd_rw),
    .o_lcd_en  (o_lcd_en),
    .o_lcd_on  (o_lcd_on)
  );

  int checks = 0;
  int errors = 0;

  // Log {rs, data} at every rising EN seen on the falling clock edge.
  logic       prev_en = 1'b0;
  logic [8:0] plog[$];
  always @(negedge clk) begin
    if (o_lcd_en && !prev_en) plog.push_back({o_lcd_rs, o_lcd_data});
    prev_en <= o_lcd_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    i_req_vld  = 1'b1;
    i_req_data = w;
    tick();
    i_req_vld  = 1'b0;
    i_req_data = 32'h0;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n = 0;
    while (o_status[0] && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, {31'd0, o_status[0]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset
    repeat (3) tick();
    check("rst_data", {24'd0, o_lcd_data}, 32'h0);
    check("rst_rs", {31'd0, o_lcd_rs}, 32'h0);
    check("rst_en", {31'd0, o_lcd_en}, 32'h0);
    check("rst_on", {31'd0, o_lcd_on}, 32'h0);
    check("rst_rw", {31'd0, o_lcd_rw}, 32'h0);
    check("rst_status", o_status, 32'h0);
    check("rst_rdy", {31'd0, o_req_rdy}, 32'h1);
    i_rst = 1'b1;
    tick();

    // Single data write
    base = plog.size();
    push(32'h0000_0241);
    check("t2_status_e0", o_status, 32'h1);
    tick();
    check("t2_data_e1", {24'd0, o_lcd_data}, 32'h41);
    check("t2_rs_e1", {31'd0, o_lcd_rs}, 32'h1);
    check("t2_en_e1", {31'd0, o_lcd_en}, 32'h0);
    for (int e = 2; e <= 12; e++) begin
      tick();
      check($sformatf("t2_en_e%0d", e), {31'd0, o_lcd_en}, (e >= 3 && e <= 5) ? 32'h1 : 32'h0);
      if (e == 11) check("t2_busy_e11", {31'd0, o_status[0]}, 32'h1);
    end
    check("t2_status_e12", o_status, 32'h0);
    check("t2_pulses", plog.size() - base, 32'd1);

    // Clear command then a normal command
    base = plog.size();
    push(32'h0000_0001);
    tick();
    check("t3_rs", {31'd0, o_lcd_rs}, 32'h0);
    check("t3_data", {24'd0, o_lcd_data}, 32'h01);
    for (int e = 2; e <= 27; e++) begin
      tick();
      if (e == 26) check("t3_busy_e26", {31'd0, o_status[0]}, 32'h1);
      if (e == 27) check("t3_busy_e27", {31'd0, o_status[0]}, 32'h0);
    end
    check("t3_clr_pulses", plog.size() - base, 32'd1);
    if (plog.size() > base) check("t3_clr_word", {23'd0, plog[base]}, 32'h001);
    base = plog.size();
    push(32'h0000_0080);
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 11) check("t3_cmd_busy_e11", {31'd0, o_status[0]}, 32'h1);
      if (e == 12) check("t3_cmd_busy_e12", {31'd0, o_status[0]}, 32'h0);
    end
    if (plog.size() > base) check("t3_cmd_word", {23'd0, plog[base]}, 32'h080);
    else check("t3_cmd_pulses", plog.size() - base, 32'd1);

    // Burst overflow
    base = plog.size();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        check("t4_rdy_e5", {31'd0, o_req_rdy}, 32'h0);
        check("t4_full_e5", o_status, 32'h3);
      end
      push(32'h0000_0210 + 32'(i));
    end
    check("t4_ovf", o_status, 32'h7);
    drain("t4_drain", 200);
    check("t4_status_end", o_status, 32'h4);
    check("t4_pulses", plog.size() - base, 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (plog.size() > base + i)
        check($sformatf("t4_word%0d", i), {23'd0, plog[base+i]}, 32'h110 + 32'(i));
    end

    // Reset mid-operation
    push(32'h0000_0220);
    push(32'h0000_0221);
    push(32'h0000_0222);
    tick();
    check("t5_en_before", {31'd0, o_lcd_en}, 32'h1);
    check("t5_status_before", o_status, 32'h5);
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    check("t5_en_after", {31'd0, o_lcd_en}, 32'h0);
    check("t5_status_after", o_status, 32'h0);
    check("t5_data_after", {24'd0, o_lcd_data}, 32'h0);
    base = plog.size();
    repeat (40) tick();
    check("t5_no_pulses", plog.size() - base, 32'd0);
    check("t5_idle", o_status, 32'h0);
    base = plog.size();
    push(32'h0000_0233);
    drain("t5_drain", 40);
    check("t5_new_pulses", plog.size() - base, 32'd1);
    if (plog.size() > base) check("t5_new_word", {23'd0, plog[base]}, 32'h133);

    // Control-only and overflow clear
    base = plog.size();
    push(32'hC000_0000);
    check("t6_on", {31'd0, o_lcd_on}, 32'h1);
    check("t6_ctrl_status", o_status, 32'h0);
    repeat (15) tick();
    check("t6_ctrl_pulses", plog.size() - base, 32'd0);
    base = plog.size();
    for (int i = 0; i < 5; i++) push(32'h8000_0250 + 32'(i));
    check("t6_full", o_status, 32'h3);
    i_req_vld  = 1'b1;
    i_req_data = 32'h0000_0260;
    i_ovf_clr  = 1'b1;
    tick();
    i_req_vld  = 1'b0;
    i_req_data = 32'h0;
    i_ovf_clr  = 1'b0;
    check("t6_set_wins", o_status, 32'h7);
    check("t6_on_kept", {31'd0, o_lcd_on}, 32'h1);
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    check("t6_ovf_cleared", {31'd0, o_status[2]}, 32'h0);
    drain("t6_drain", 200);
    check("t6_pulses", plog.size() - base, 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (plog.size() > base + i)
        check($sformatf("t6_word%0d", i), {23'd0, plog[base+i]}, 32'h150 + 32'(i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
